// File: rtl/proc_control.sv
// ---------------------------------------------------------------------------
// proc_control
//
// Control sequencer for the simple 9-bit processor. It fetches an
// instruction word from DIN in step T0. It then walks through steps T1..T3
// and drives the register-select codes for the Rin/Rout 3-to-8 decoders
// and the datapath strobes for A, G, the adder/subtractor and the DIN mux.
//
// Instruction word layout (MSB first):
//   [DATA_W-1 -: 3] opcode, [DATA_W-4 -: 3] X, [DATA_W-7 -: 3] Y
//   000 mv Rx,Ry | 001 mvi Rx,#D | 010 add Rx,Ry | 011 sub Rx,Ry
//   100..111 reserved (treated as a single-step no-op)
//
// Ports:
//   Clock   in   rising-edge clock
//   Resetn  in   asynchronous active-low reset
//   Run     in   start request, only looked at in T0
//   DIN     in   instruction word (T0) / immediate data (T1 of mvi)
//   Xsel    out  register code to the Rin decoder (000 when XselEn = 0)
//   XselEn  out  Rin decoder enable
//   Ysel    out  register code to the Rout decoder (000 when YselEn = 0)
//   YselEn  out  Rout decoder enable
//   IRin    out  IR load strobe (IR itself lives in here)
//   DINout  out  drive DIN onto the bus
//   Ain     out  load A from the bus
//   Gin     out  load G from the adder
//   Gout    out  drive G onto the bus
//   AddSub  out  0 = add, 1 = subtract
//   Done    out  last step of the current instruction
//   Tstep   out  current time step (0..3)
// ---------------------------------------------------------------------------
module proc_control #(
    parameter int DATA_W = 9
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [2:0]        Xsel,
    output logic              XselEn,
    output logic [2:0]        Ysel,
    output logic              YselEn,
    output logic              IRin,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              AddSub,
    output logic              Done,
    output logic [1:0]        Tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    tstep_t            tState;
    logic [DATA_W-1:0] irReg;

    logic [2:0] opcode;
    logic [2:0] xField;
    logic [2:0] yField;
    logic       isAddSub;

    // Field extraction from the held instruction word
    assign opcode   = irReg[DATA_W-1 -: 3];
    assign xField   = irReg[DATA_W-4 -: 3];
    assign yField   = irReg[DATA_W-7 -: 3];
    assign isAddSub = (opcode == OP_ADD) || (opcode == OP_SUB);

    // Step register and instruction register. T0 waits for Run and latches
    // the instruction; add/sub run through T3, all other opcodes end in T1.
    // A T2/T3 reached with a non-add/sub IR (not normally reachable) simply
    // falls back to T0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tState <= T0;
            irReg  <= '0;
        end else begin
            case (tState)
                T0: begin
                    if (Run) begin
                        irReg  <= DIN;
                        tState <= T1;
                    end
                end
                T1: tState <= isAddSub ? T2 : T0;
                T2: tState <= isAddSub ? T3 : T0;
                T3: tState <= T0;
                default: tState <= T0;
            endcase
        end
    end

    logic [2:0] xCode;
    logic [2:0] yCode;
    logic       xEnable;
    logic       yEnable;

    // Output decode from the current step and the held instruction. Only
    // IRin also looks at Run, and it is gated by Resetn so it stays low
    // while reset is held. The decoder codes are zeroed whenever their
    // enable is low, so the decoders see a clean 000.
    always_comb begin
        xCode   = 3'b000;
        yCode   = 3'b000;
        xEnable = 1'b0;
        yEnable = 1'b0;
        IRin    = 1'b0;
        DINout  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;

        case (tState)
            T0: begin
                IRin = Run & Resetn;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        yCode   = yField;
                        yEnable = 1'b1;
                        xCode   = xField;
                        xEnable = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        xCode   = xField;
                        xEnable = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        // First operand Rx goes over the bus into A
                        yCode   = xField;
                        yEnable = 1'b1;
                        Ain     = 1'b1;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (isAddSub) begin
                    yCode   = yField;
                    yEnable = 1'b1;
                    Gin     = 1'b1;
                    AddSub  = opcode[0];
                end
            end
            T3: begin
                if (isAddSub) begin
                    Gout    = 1'b1;
                    xCode   = xField;
                    xEnable = 1'b1;
                    Done    = 1'b1;
                end
            end
            default: begin
                xCode = 3'b000;
            end
        endcase
    end

    // Final decoder-facing outputs
    assign Xsel   = xEnable ? xCode : 3'b000;
    assign XselEn = xEnable;
    assign Ysel   = yEnable ? yCode : 3'b000;
    assign YselEn = yEnable;
    assign Tstep  = tState;

    // Bus and register-write exclusivity
    xselAinExclusive : assert property (@(posedge Clock) disable iff (!Resetn)
        !(XselEn && Ain));
    goutDinExclusive : assert property (@(posedge Clock) disable iff (!Resetn)
        !(Gout && DINout));

endmodule

// File: tb/tb_proc_control.sv
// ---------------------------------------------------------------------------
// tb_proc_control
//
// Directed self-checking bench for proc_control. Inputs are driven on the
// falling edge and the outputs are sampled there, away from the rising
// edge. All outputs are compared at once as one packed word built by
// packOut, against hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_proc_control;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] DIN;
    logic [2:0] Xsel;
    logic       XselEn;
    logic [2:0] Ysel;
    logic       YselEn;
    logic       IRin;
    logic       DINout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       AddSub;
    logic       Done;
    logic [1:0] Tstep;

    int checkCount;
    int errorCount;

    proc_control #(.DATA_W(9)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .Xsel   (Xsel),
        .XselEn (XselEn),
        .Ysel   (Ysel),
        .YselEn (YselEn),
        .IRin   (IRin),
        .DINout (DINout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .AddSub (AddSub),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    // 10 ns clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Packs every output into one word:
    // {Xsel, XselEn, Ysel, YselEn, IRin, DINout, Ain, Gin, Gout, AddSub, Done, Tstep}
    function automatic logic [16:0] packOut(
        input logic [2:0] xs, input logic xe,
        input logic [2:0] ys, input logic ye,
        input logic irin, input logic dinout, input logic ain,
        input logic gin, input logic gout, input logic addsub,
        input logic done, input logic [1:0] ts);
        return {xs, xe, ys, ye, irin, dinout, ain, gin, gout, addsub, done, ts};
    endfunction

    // Single comparison point: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [16:0] observed,
                               input logic [16:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %05h expected %05h", tag, observed, expected);
        end
    endtask

    // Compares the live DUT outputs against an expected packed word
    task automatic checkNow(input string tag, input logic [16:0] expected);
        checkOutput(tag, packOut(Xsel, XselEn, Ysel, YselEn, IRin, DINout,
                                 Ain, Gin, Gout, AddSub, Done, Tstep), expected);
    endtask

    // Sets Run/DIN for the next rising edge
    task automatic applyStimulus(input logic run, input logic [8:0] din);
        Run = run;
        DIN = din;
    endtask

    // Advance one clock and land on the following falling edge
    task automatic nextCycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    localparam logic [16:0] ALL_ZERO = 17'd0;

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Reset held with Run high: everything 0, IRin forced low
        Resetn = 1'b0;
        applyStimulus(1'b1, 9'h050);
        #1;
        checkNow("reset.async", ALL_ZERO);
        nextCycle();
        nextCycle();
        checkNow("reset.held", ALL_ZERO);

        // Release: T0, IRin follows Run
        Resetn = 1'b1;
        #1;
        checkNow("release.t0", packOut(3'd0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0));

        // mvi R2, #D
        @(negedge Clock);
        checkNow("mvi.t1", packOut(3'd2,1'b1,3'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1));
        applyStimulus(1'b0, 9'h0A5);
        nextCycle();
        checkNow("mvi.back.t0", ALL_ZERO);

        // add R1,R3 with Run toggling during T1..T3
        applyStimulus(1'b1, 9'h08B);
        nextCycle();
        checkNow("add.t1", packOut(3'd0,1'b0,3'd1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1));
        applyStimulus(1'b0, 9'h1FF);
        nextCycle();
        checkNow("add.t2", packOut(3'd0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd2));
        applyStimulus(1'b1, 9'h1FF);
        nextCycle();
        checkNow("add.t3", packOut(3'd1,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd3));

        // sub R0,R7 fetched right after Done
        applyStimulus(1'b1, 9'h0C7);
        nextCycle();
        checkNow("sub.t0", packOut(3'd0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0));
        nextCycle();
        checkNow("sub.t1", packOut(3'd0,1'b0,3'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1));
        nextCycle();
        checkNow("sub.t2", packOut(3'd0,1'b0,3'd7,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd2));
        nextCycle();
        checkNow("sub.t3", packOut(3'd0,1'b1,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd3));

        // mv R5,R6 back-to-back
        applyStimulus(1'b1, 9'h02E);
        nextCycle();
        checkNow("mv.t0", packOut(3'd0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0));
        nextCycle();
        checkNow("mv.t1", packOut(3'd5,1'b1,3'd6,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1));

        // Reserved opcode: single step, Done only
        applyStimulus(1'b1, 9'h1FF);
        nextCycle();
        checkNow("rsv.t0", packOut(3'd0,1'b0,3'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0));
        nextCycle();
        checkNow("rsv.t1", packOut(3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1));
        applyStimulus(1'b0, 9'h000);
        nextCycle();
        checkNow("rsv.back.t0", ALL_ZERO);

        // add aborted by reset in T2
        applyStimulus(1'b1, 9'h08B);
        nextCycle();
        checkNow("abort.t1", packOut(3'd0,1'b0,3'd1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1));
        nextCycle();
        checkNow("abort.t2", packOut(3'd0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd2));
        Resetn = 1'b0;
        #1;
        checkNow("abort.async", ALL_ZERO);
        nextCycle();
        checkNow("abort.held", ALL_ZERO);

        // Release with Run low: stays idle in T0, no Done ever appears
        applyStimulus(1'b0, 9'h08B);
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkNow($sformatf("idle.t0.%0d", i), ALL_ZERO);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
